// File: rtl/load_use_scoreboard_if.sv
// IF/ID-side signal bundle for the load-use interlock.
// The pipeline control drives the master side; the scoreboard is the slave.
interface load_use_scoreboard_if #(
    parameter int REG_AW = 5
);
    logic              mem_to_reg_id;
    logic [REG_AW-1:0] rd_id;
    logic [0:31]       instruction_if;
    logic              mem_wait;
    logic              flush;
    logic              stall;
    logic              load_pending;

    modport master (
        output mem_to_reg_id,
        output rd_id,
        output instruction_if,
        output mem_wait,
        output flush,
        input  stall,
        input  load_pending
    );

    modport slave (
        input  mem_to_reg_id,
        input  rd_id,
        input  instruction_if,
        input  mem_wait,
        input  flush,
        output stall,
        output load_pending
    );
endinterface

// File: rtl/load_use_scoreboard.sv
// Load-use interlock tracking loads over LOAD_LAT cycles of memory latency.
// Optional saturating stall counter enabled by defining STALL_CNT_EN.
module load_use_scoreboard #(
    parameter int LOAD_LAT = 1,
    parameter int REG_AW   = 5,
    parameter int CNT_W    = 16
) (
    input  logic clk,
    input  logic reset_n,
    load_use_scoreboard_if.slave pipe
`ifdef STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_count
`endif
);
    localparam int NS = (LOAD_LAT > 1) ? LOAD_LAT - 1 : 1;

    logic [5:0]        opcode;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              jnr;
    logic              rtype;
    logic              store;
    logic              uses_rs1;
    logic              uses_rs2;
    logic              hit1;
    logic              hit2;
    logic              capture;

    logic [NS-1:0]     v;
    logic [REG_AW-1:0] rd [NS];

    assign opcode = pipe.instruction_if[0:5];
    assign rs1    = pipe.instruction_if[6 +: REG_AW];
    assign rs2    = pipe.instruction_if[6 + REG_AW +: REG_AW];

    assign jnr      = (opcode[5:1] == 5'b00001);
    assign rtype    = (opcode == 6'b000000);
    assign store    = (opcode[5:1] == 5'b10100) || (opcode == 6'b101011);
    assign uses_rs1 = ~jnr & ~store;
    assign uses_rs2 = ~jnr & (rtype | store);

    // A squashed ID load never reaches memory, so it must not occupy a slot.
    assign capture = pipe.mem_to_reg_id & ~pipe.flush;

    generate
        if (LOAD_LAT > 1) begin : g_slots
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    v <= '0;
                    for (int k = 0; k < NS; k++) rd[k] <= '0;
                end else if (!pipe.mem_wait) begin
                    for (int k = NS - 1; k > 0; k--) begin
                        v[k]  <= v[k-1];
                        rd[k] <= rd[k-1];
                    end
                    v[0]  <= capture;
                    rd[0] <= pipe.rd_id;
                end
            end
        end else begin : g_no_slots
            always_comb begin
                v     = '0;
                rd[0] = '0;
            end
        end
    endgenerate

    always_comb begin
        hit1 = pipe.mem_to_reg_id && (pipe.rd_id == rs1);
        hit2 = pipe.mem_to_reg_id && (pipe.rd_id == rs2);
        for (int k = 0; k < NS; k++) begin
            hit1 = hit1 | (v[k] && (rd[k] == rs1));
            hit2 = hit2 | (v[k] && (rd[k] == rs2));
        end
    end

    // r0 is hardwired zero, so a matching r0 destination is never a hazard.
    assign pipe.stall = ((hit1 & uses_rs1 & |rs1) |
                         (hit2 & uses_rs2 & |rs2)) & ~pipe.flush;
    assign pipe.load_pending = |v;

`ifdef STALL_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_count <= '0;
        end else if (pipe.stall && !pipe.mem_wait && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end
`else
    logic [CNT_W-1:0] unused_cnt;
    assign unused_cnt = '0;
`endif

    logic unused_instr;
    assign unused_instr = &{1'b0, pipe.instruction_if};
endmodule

// File: tb/tb_load_use_scoreboard.sv
// Randomised bench for load_use_scoreboard against an age-list load model.
// Runs a LOAD_LAT=1 and a LOAD_LAT=3 instance side by side on one stimulus.
module tb_load_use_scoreboard;
    localparam int LB = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [3:0] cnt_a;
    logic [3:0] cnt_b;

    load_use_scoreboard_if #(.REG_AW(5)) pa ();
    load_use_scoreboard_if #(.REG_AW(5)) pb ();

    load_use_scoreboard #(.LOAD_LAT(1), .REG_AW(5), .CNT_W(4)) dut_a (
        .clk(clk),
        .reset_n(reset_n),
        .pipe(pa)
`ifdef STALL_CNT_EN
        , .stall_count(cnt_a)
`endif
    );

    load_use_scoreboard #(.LOAD_LAT(LB), .REG_AW(5), .CNT_W(4)) dut_b (
        .clk(clk),
        .reset_n(reset_n),
        .pipe(pb)
`ifdef STALL_CNT_EN
        , .stall_count(cnt_b)
`endif
    );

`ifndef STALL_CNT_EN
    assign cnt_a = '0;
    assign cnt_b = '0;
`endif

    always #5 clk = ~clk;

    // Loads that left ID, youngest first; -1 marks a cycle with no load.
    int hist [8];
    int cnt_m;
    int pass_n;
    int total_n;

    localparam int K_RTYPE = 0, K_J = 1, K_JAL = 2, K_SW = 3;
    localparam int K_SB = 4, K_SH = 5, K_LW = 6, K_ADDI = 7;

    task automatic chk(input string tag, input int got, input int exp);
        total_n++;
        if (got == exp) pass_n++;
        else $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [5:0] op_of(input int kind);
        case (kind)
            K_RTYPE: return 6'b000000;
            K_J:     return 6'b000010;
            K_JAL:   return 6'b000011;
            K_SW:    return 6'b101011;
            K_SB:    return 6'b101000;
            K_SH:    return 6'b101001;
            K_LW:    return 6'b100011;
            default: return 6'b001000;
        endcase
    endfunction

    function automatic bit reads_rs1(input int kind);
        return !(kind inside {K_J, K_JAL, K_SW, K_SB, K_SH});
    endfunction

    function automatic bit reads_rs2(input int kind);
        return kind inside {K_RTYPE, K_SW, K_SB, K_SH};
    endfunction

    function automatic bit exp_stall(input int lat, input bit ld, input int rd,
                                     input int kind, input int r1, input int r2,
                                     input bit fl);
        int set[$];
        bit h;
        h = 0;
        if (ld) set.push_back(rd);
        for (int k = 0; k < lat - 1; k++)
            if (hist[k] >= 0) set.push_back(hist[k]);
        foreach (set[i]) begin
            if (set[i] != 0 && reads_rs1(kind) && set[i] == r1) h = 1;
            if (set[i] != 0 && reads_rs2(kind) && set[i] == r2) h = 1;
        end
        return h && !fl;
    endfunction

    function automatic bit exp_pending(input int lat);
        bit p;
        p = 0;
        for (int k = 0; k < lat - 1; k++)
            if (hist[k] >= 0) p = 1;
        return p;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 8; k++) hist[k] = -1;
        cnt_m = 0;
    endtask

    task automatic drive(input bit ld, input int rd, input logic [0:31] ins,
                         input bit mw, input bit fl);
        pa.mem_to_reg_id = ld;  pb.mem_to_reg_id = ld;
        pa.rd_id = rd[4:0];     pb.rd_id = rd[4:0];
        pa.instruction_if = ins; pb.instruction_if = ins;
        pa.mem_wait = mw;       pb.mem_wait = mw;
        pa.flush = fl;          pb.flush = fl;
    endtask

    task automatic step(input bit ld, input int rd, input int kind,
                        input int r1, input int r2, input bit mw, input bit fl,
                        output bit sa, output bit sb);
        logic [0:31] ins;
        bit ea, eb;
        @(negedge clk);
        ins = $urandom;
        ins[0:5] = op_of(kind);
        ins[6:10] = r1[4:0];
        ins[11:15] = r2[4:0];
        drive(ld, rd, ins, mw, fl);
        #1;
        ea = exp_stall(1, ld, rd, kind, r1, r2, fl);
        eb = exp_stall(LB, ld, rd, kind, r1, r2, fl);
        sa = pa.stall;
        sb = pb.stall;
        chk("stall_l1", int'(sa), int'(ea));
        chk("stall_l3", int'(sb), int'(eb));
        chk("pend_l1", int'(pa.load_pending), int'(exp_pending(1)));
        chk("pend_l3", int'(pb.load_pending), int'(exp_pending(LB)));
`ifdef STALL_CNT_EN
        chk("count_l3", int'(cnt_b), cnt_m);
`endif
        @(posedge clk);
        if (!mw) begin
            for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = (ld && !fl) ? rd : -1;
            if (eb && cnt_m < 15) cnt_m++;
        end
    endtask

    initial begin
        bit sa, sb;
        pass_n = 0;
        total_n = 0;
        model_reset();
        drive(1'b0, 0, 32'h0, 1'b0, 1'b0);
        #2;
        chk("rst_stall_l3", int'(pb.stall), 0);
        chk("rst_pend_l3", int'(pb.load_pending), 0);
`ifdef STALL_CNT_EN
        chk("rst_count", int'(cnt_b), 0);
`endif
        @(negedge clk);
        reset_n = 1'b1;

        // lw r5 in ID, add r1,r5,r2 in IF
        step(1, 5, K_RTYPE, 5, 2, 0, 0, sa, sb);
        chk("t1_on", int'(sa), 1);
        step(0, 0, K_RTYPE, 5, 2, 0, 0, sa, sb);
        chk("t1_off", int'(sa), 0);

        // lw r7 then dependent sw r7,0(r4) on the 3-cycle instance
        step(1, 7, K_SW, 4, 7, 0, 0, sa, sb);
        chk("t2_c1", int'(sb), 1);
        step(0, 0, K_SW, 4, 7, 0, 0, sa, sb);
        chk("t2_c2", int'(sb), 1);
        step(0, 0, K_SW, 4, 7, 0, 0, sa, sb);
        chk("t2_c3", int'(sb), 1);
        step(0, 0, K_SW, 4, 7, 0, 0, sa, sb);
        chk("t2_c4", int'(sb), 0);

        step(1, 0, K_RTYPE, 0, 0, 0, 0, sa, sb);
        chk("t3_r0", int'(sb), 0);
        step(1, 3, K_J, 3, 3, 0, 0, sa, sb);
        chk("t3_jump", int'(sb), 0);
        step(1, 3, K_ADDI, 2, 3, 0, 0, sa, sb);
        chk("t3_imm", int'(sb), 0);
        repeat (3) step(0, 0, K_RTYPE, 0, 0, 0, 0, sa, sb);

        // load parked in a slot while memory waits
        step(1, 4, K_RTYPE, 1, 1, 0, 0, sa, sb);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, K_RTYPE, 4, 1, 1, 0, sa, sb);
            chk("t4_hold", int'(sb), 1);
        end
        step(0, 0, K_RTYPE, 4, 1, 0, 0, sa, sb);
        step(0, 0, K_RTYPE, 4, 1, 0, 0, sa, sb);
        step(0, 0, K_RTYPE, 4, 1, 0, 0, sa, sb);
        chk("t4_release", int'(sb), 0);

        step(1, 6, K_RTYPE, 6, 6, 0, 1, sa, sb);
        chk("t5_flush", int'(sb), 0);
        step(0, 0, K_RTYPE, 6, 6, 0, 0, sa, sb);
        chk("t5_nocap", int'(sb), 0);

        // asynchronous reset while a slot still holds a hazard
        step(1, 9, K_RTYPE, 9, 9, 0, 0, sa, sb);
        #2;
        drive(1'b0, 9, pb.instruction_if, 1'b0, 1'b0);
        #1;
        chk("t5_pre_rst", int'(pb.stall), 1);
        reset_n = 1'b0;
        #1;
        chk("t5_rst_stall", int'(pb.stall), 0);
        chk("t5_rst_pend", int'(pb.load_pending), 0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;

`ifdef STALL_CNT_EN
        for (int i = 0; i < 24; i++)
            step(1, 5, K_RTYPE, 5, 5, (i % 6) == 2, 0, sa, sb);
        #1;
        chk("t6_sat", int'(cnt_b), 15);
`endif

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 1), $urandom_range(0, 7),
                 $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 7), $urandom_range(0, 5) == 0,
                 $urandom_range(0, 7) == 0, sa, sb);
        end

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
